// File: rtl/bist_tpg_if.sv
// Handshake and observation bundle between the BIST pattern generator and its user.
// The master side drives start and scan controls; the slave (bist_tpg) drives patterns and status.
interface bist_tpg_if #(
    parameter int NBIT = 6
);
    logic            start;
    logic            scan_en;
    logic            scan_in;
    logic            scan_out;
    logic [NBIT-1:0] pattern;
    logic [3:0]      req_o;
    logic            test_mode;
    logic            cut_rst;
    logic            misr_en;
    logic            done;
    logic [7:0]      pat_cnt;

    modport master (
        output start, scan_en, scan_in,
        input  scan_out, pattern, req_o, test_mode, cut_rst, misr_en, done, pat_cnt
    );

    modport slave (
        input  start, scan_en, scan_in,
        output scan_out, pattern, req_o, test_mode, cut_rst, misr_en, done, pat_cnt
    );
endinterface

// File: rtl/bist_tpg.sv
// BIST test-pattern generator: a 6-bit LFSR (x^6+x^5+1) that can be seeded over a
// serial scan path, then stepped through NPAT patterns while driving the arbiter
// under test and the enable of its signature register.
module bist_tpg #(
    parameter int              NBIT = 6,
    parameter logic [NBIT-1:0] SEED = 6'b111111,
    parameter int              NPAT = 63
) (
    input  logic        clk,
    input  logic        rst,
    bist_tpg_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Count value seen on the final RUN cycle.
    localparam logic [7:0] LAST_CNT = 8'(NPAT - 1);

    state_t          state;
    state_t          state_nx;
    logic [NBIT-1:0] lfsr;
    logic [7:0]      cnt;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; scan_en beats start in IDLE, and each is ignored outside the states that use it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.scan_en)    state_nx = SCAN;
                else if (bus.start) state_nx = ARM;
            end
            SCAN:    if (!bus.scan_en) state_nx = IDLE;
            ARM:     state_nx = RUN;
            RUN:     if (cnt == LAST_CNT) state_nx = DONE;
            DONE:    if (!bus.start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // LFSR and pattern counter: shift-in during SCAN, seed fix-up in ARM, advance during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
            cnt  <= 8'd0;
        end else begin
            case (state)
                SCAN: if (bus.scan_en) lfsr <= {lfsr[NBIT-2:0], bus.scan_in};
                ARM: begin
                    cnt <= 8'd0;
                    // An all-zero LFSR would lock up, so replace it with the seed.
                    if (lfsr == '0) lfsr <= SEED;
                end
                RUN: begin
                    lfsr <= {lfsr[NBIT-2:0], lfsr[NBIT-1] ^ lfsr[NBIT-2]};
                    cnt  <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state and LFSR only, so no input reaches an output combinationally.
    always_comb begin
        bus.pattern   = lfsr;
        bus.scan_out  = lfsr[NBIT-1];
        bus.pat_cnt   = cnt;
        bus.req_o     = 4'b0000;
        bus.test_mode = 1'b0;
        bus.cut_rst   = 1'b0;
        bus.misr_en   = 1'b0;
        bus.done      = 1'b0;
        case (state)
            ARM: begin
                bus.test_mode = 1'b1;
                bus.cut_rst   = 1'b1;
            end
            RUN: begin
                bus.test_mode = 1'b1;
                bus.misr_en   = 1'b1;
                bus.req_o     = lfsr[3:0];
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bist_tpg.sv
// Self-checking bench for bist_tpg: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a phase-level reference model.
module tb_bist_tpg;
    localparam int              NBIT = 6;
    localparam logic [NBIT-1:0] SEED = 6'b111111;
    localparam int              NPAT = 63;

    localparam int P_IDLE = 0;
    localparam int P_SCAN = 1;
    localparam int P_ARM  = 2;
    localparam int P_RUN  = 3;
    localparam int P_DONE = 4;

    logic clk;
    logic rst;
    bist_tpg_if #(.NBIT(NBIT)) bus();

    bist_tpg #(.NBIT(NBIT), .SEED(SEED), .NPAT(NPAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: operating phase, LFSR contents and pattern count.
    int         m_phase;
    logic [5:0] m_lfsr;
    int         m_cnt;
    logic [5:0] seq [63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Maximal-length sequence of x^6+x^5+1 starting from the seed.
    task automatic build_seq();
        logic [5:0] v;
        v = SEED;
        for (int i = 0; i < 63; i++) begin
            seq[i] = v;
            v = {v[4:0], v[5] ^ v[4]};
        end
    endtask

    function automatic logic [5:0] seq_next(input logic [5:0] v);
        int j;
        j = 0;
        for (int i = 0; i < 63; i++) if (seq[i] == v) j = i;
        return seq[(j + 1) % 63];
    endfunction

    task automatic model_step(input logic r, input logic s, input logic se, input logic si);
        if (r) begin
            m_phase = P_IDLE;
            m_lfsr  = SEED;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (se)     m_phase = P_SCAN;
                    else if (s) m_phase = P_ARM;
                end
                P_SCAN: begin
                    if (se) m_lfsr = {m_lfsr[4:0], si};
                    else    m_phase = P_IDLE;
                end
                P_ARM: begin
                    m_cnt = 0;
                    if (m_lfsr == 6'd0) m_lfsr = SEED;
                    m_phase = P_RUN;
                end
                P_RUN: begin
                    m_lfsr = seq_next(m_lfsr);
                    m_cnt++;
                    if (m_cnt == NPAT) m_phase = P_DONE;
                end
                default: if (!s) m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic check_model();
        chk("m_pattern",   32'(bus.pattern),   32'(m_lfsr));
        chk("m_scan_out",  32'(bus.scan_out),  32'(m_lfsr[5]));
        chk("m_req_o",     32'(bus.req_o),     (m_phase == P_RUN) ? 32'(m_lfsr[3:0]) : 32'd0);
        chk("m_test_mode", 32'(bus.test_mode), 32'(m_phase == P_ARM || m_phase == P_RUN));
        chk("m_cut_rst",   32'(bus.cut_rst),   32'(m_phase == P_ARM));
        chk("m_misr_en",   32'(bus.misr_en),   32'(m_phase == P_RUN));
        chk("m_done",      32'(bus.done),      32'(m_phase == P_DONE));
        chk("m_pat_cnt",   32'(bus.pat_cnt),   32'(m_cnt));
    endtask

    task automatic cycle(input logic r, input logic s, input logic se, input logic si);
        rst         = r;
        bus.start   = s;
        bus.scan_en = se;
        bus.scan_in = si;
        @(posedge clk);
        model_step(r, s, se, si);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [5:0] exp_pat [7];
        logic [5:0] sb;
        logic [5:0] pr;
        logic       seen [64];
        int         idx;
        int         misr_cnt;
        int         distinct;

        rst = 1'b1; bus.start = 1'b0; bus.scan_en = 1'b0; bus.scan_in = 1'b0;
        m_phase = P_IDLE; m_lfsr = SEED; m_cnt = 0;
        build_seq();
        exp_pat = '{6'b111111, 6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000001};

        // Reset values.
        @(negedge clk);
        cycle(1, 0, 0, 0);
        chk("rst_pattern",   32'(bus.pattern),   32'h3f);
        chk("rst_scan_out",  32'(bus.scan_out),  32'd1);
        chk("rst_req_o",     32'(bus.req_o),     32'd0);
        chk("rst_test_mode", 32'(bus.test_mode), 32'd0);
        chk("rst_cut_rst",   32'(bus.cut_rst),   32'd0);
        chk("rst_misr_en",   32'(bus.misr_en),   32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_pat_cnt",   32'(bus.pat_cnt),   32'd0);

        // Full run from the seed, start held high throughout.
        cycle(0, 1, 0, 0);
        chk("arm_cut_rst", 32'(bus.cut_rst), 32'd1);
        chk("arm_misr_en", 32'(bus.misr_en), 32'd0);
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        idx = 0; misr_cnt = 0;
        for (int c = 0; c < 100 && !bus.done; c++) begin
            cycle(0, 1, 0, 0);
            if (bus.misr_en) begin
                if (idx < 7) begin
                    chk("run_pattern", 32'(bus.pattern), 32'(exp_pat[idx]));
                    chk("run_req_o",   32'(bus.req_o),   32'(exp_pat[idx][3:0]));
                end
                seen[bus.pattern] = 1'b1;
                misr_cnt++;
                idx++;
            end
        end
        chk("run_reached_done", 32'(bus.done), 32'd1);
        distinct = 0;
        for (int i = 1; i < 64; i++) if (seen[i]) distinct++;
        chk("run_misr_cycles", 32'(misr_cnt), 32'd63);
        chk("run_distinct",    32'(distinct), 32'd63);
        chk("run_zero_seen",   32'(seen[0]),  32'd0);
        chk("done_pattern",    32'(bus.pattern), 32'h3f);
        chk("done_pat_cnt",    32'(bus.pat_cnt), 32'd63);

        // Start held in DONE: no re-run; drop for a cycle, then re-run from the held value.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            chk("done_hold", 32'(bus.done), 32'd1);
            chk("done_no_misr", 32'(bus.misr_en), 32'd0);
        end
        cycle(0, 0, 0, 0);
        chk("done_to_idle", 32'(bus.done), 32'd0);
        cycle(0, 1, 0, 0);
        chk("rerun_cut_rst", 32'(bus.cut_rst), 32'd1);
        cycle(0, 0, 0, 0);
        chk("rerun_first_pattern", 32'(bus.pattern), 32'h3f);
        chk("rerun_misr_en", 32'(bus.misr_en), 32'd1);

        // Scan in 1,0,1,0,0,0 and run from it.
        cycle(1, 0, 0, 0);
        sb = 6'b101000;
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 1, sb[5-k]);
        chk("scan_pattern", 32'(bus.pattern), 32'h28);
        cycle(0, 0, 0, 0);
        chk("scan_idle_hold", 32'(bus.pattern), 32'h28);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("scan_run_first", 32'(bus.pattern), 32'h28);
        chk("scan_run_req",   32'(bus.req_o),   32'h8);

        // Reset at RUN cycle 10 with start held high.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        chk("mid_run_cnt", 32'(bus.pat_cnt), 32'd10);
        cycle(1, 1, 0, 0);
        chk("midrst_pattern", 32'(bus.pattern),   32'h3f);
        chk("midrst_misr_en", 32'(bus.misr_en),   32'd0);
        chk("midrst_pat_cnt", 32'(bus.pat_cnt),   32'd0);
        chk("midrst_test",    32'(bus.test_mode), 32'd0);
        cycle(1, 1, 1, 1);
        chk("rst_priority_cut_rst", 32'(bus.cut_rst), 32'd0);
        chk("rst_priority_pattern", 32'(bus.pattern), 32'h3f);
        cycle(0, 1, 0, 0);
        chk("post_rst_arm", 32'(bus.cut_rst), 32'd1);

        // Scan zeros over a known prior value: scan_out replays it MSB first, then ARM substitutes the seed.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 1, sb[5-k]);
        cycle(0, 0, 0, 0);
        pr = 6'b101000;
        cycle(0, 0, 1, 0);
        chk("scanout_bit5", 32'(bus.scan_out), 32'(pr[5]));
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 1, 0);
            if (k < 5) chk("scanout_order", 32'(bus.scan_out), 32'(pr[4-k]));
        end
        chk("zero_scanned", 32'(bus.pattern), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("zero_subst_first", 32'(bus.pattern), 32'h3f);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                  1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
